// File: rtl/rs_alu_issue_if.sv
// rtl/rs_alu_issue_if.sv - dispatch/wakeup/issue bundle for the ALU reservation station
// master = dispatch/wakeup/execute side, slave = the reservation station.
interface rs_alu_issue_if #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 7,
  parameter int PAYLOAD_W = 48
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 disp_valid;
  logic                 disp_ready;
  logic [PREG_W-1:0]    disp_ps1;
  logic [PREG_W-1:0]    disp_ps2;
  logic                 disp_ps1_rdy;
  logic                 disp_ps2_rdy;
  logic [PREG_W-1:0]    disp_pd;
  logic [PAYLOAD_W-1:0] disp_payload;
  logic                 wk_alu_en;
  logic [PREG_W-1:0]    wk_alu_pd;
  logic                 wk_b_en;
  logic [PREG_W-1:0]    wk_b_pd;
  logic                 wk_mem_en;
  logic [PREG_W-1:0]    wk_mem_pd;
  logic                 flush;
  logic                 iss_ready;
  logic                 read_en_alu;
  logic [PREG_W-1:0]    ps1_in_alu;
  logic [PREG_W-1:0]    ps2_in_alu;
  logic [PREG_W-1:0]    iss_pd;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [CNT_W-1:0]     count;

  modport master (
    output disp_valid, disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy, disp_pd, disp_payload,
    output wk_alu_en, wk_alu_pd, wk_b_en, wk_b_pd, wk_mem_en, wk_mem_pd, flush, iss_ready,
    input  disp_ready, read_en_alu, ps1_in_alu, ps2_in_alu, iss_pd, iss_payload, count
  );

  modport slave (
    input  disp_valid, disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy, disp_pd, disp_payload,
    input  wk_alu_en, wk_alu_pd, wk_b_en, wk_b_pd, wk_mem_en, wk_mem_pd, flush, iss_ready,
    output disp_ready, read_en_alu, ps1_in_alu, ps2_in_alu, iss_pd, iss_payload, count
  );
endinterface

// File: rtl/rs_alu_issue.sv
// rtl/rs_alu_issue.sv - ALU reservation station with PRF wakeup snooping and single issue
// Define RS_OLDEST_FIRST_EN for age-based select; default is lowest-index priority.
module rs_alu_issue #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 7,
  parameter int PAYLOAD_W = 48
) (
  input logic           clk,
  input logic           reset,
  rs_alu_issue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     rdy1;
  logic [DEPTH-1:0]     rdy2;
  logic [PREG_W-1:0]    ps1     [DEPTH];
  logic [PREG_W-1:0]    ps2     [DEPTH];
  logic [PREG_W-1:0]    pd      [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  logic [CNT_W-1:0]     count_q;
`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0]     age     [DEPTH];
  logic [IDX_W-1:0]     best_age;
`endif

  logic [2:0]           wk_en;
  logic [3*PREG_W-1:0]  wk_pd;
  logic [DEPTH-1:0]     wake1;
  logic [DEPTH-1:0]     wake2;
  logic                 d_rdy1;
  logic                 d_rdy2;
  logic                 found;
  logic [IDX_W-1:0]     sel;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 disp_ready;
  logic                 disp_fire;
  logic                 iss_fire;

  // Tag 0 is the hard-wired zero register and never produces a wakeup.
  function automatic logic hit(input logic [PREG_W-1:0] tag, input logic [2:0] en,
                               input logic [3*PREG_W-1:0] pds);
    hit = 1'b0;
    if (tag != '0) begin
      for (int p = 0; p < 3; p++) begin
        if (en[p] && (pds[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
      end
    end
  endfunction

  assign wk_en = {bus.wk_mem_en, bus.wk_b_en, bus.wk_alu_en};
  assign wk_pd = {bus.wk_mem_pd, bus.wk_b_pd, bus.wk_alu_pd};

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = hit(ps1[i], wk_en, wk_pd);
      wake2[i] = hit(ps2[i], wk_en, wk_pd);
    end
    d_rdy1 = bus.disp_ps1_rdy || (bus.disp_ps1 == '0) || hit(bus.disp_ps1, wk_en, wk_pd);
    d_rdy2 = bus.disp_ps2_rdy || (bus.disp_ps2 == '0) || hit(bus.disp_ps2, wk_en, wk_pd);
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && rdy1[i] && rdy2[i] && (!found || (age[i] > best_age))) begin
        found    = 1'b1;
        sel      = IDX_W'(i);
        best_age = age[i];
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && rdy1[i] && rdy2[i]) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
`endif
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Dispatch only ever targets a slot that was free before the edge, so it cannot
  // collide with the slot being issued this cycle.
  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign disp_fire  = bus.disp_valid && disp_ready && free_found && !bus.flush;
  assign iss_fire   = found && bus.iss_ready && !bus.flush;

  assign bus.disp_ready  = disp_ready;
  assign bus.count       = count_q;
  assign bus.read_en_alu = iss_fire;
  assign bus.ps1_in_alu  = iss_fire ? ps1[sel]     : '0;
  assign bus.ps2_in_alu  = iss_fire ? ps2[sel]     : '0;
  assign bus.iss_pd      = iss_fire ? pd[sel]      : '0;
  assign bus.iss_payload = iss_fire ? payload[sel] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= '0;
      rdy1    <= '0;
      rdy2    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      valid   <= '0;
      count_q <= '0;
    end else begin
      rdy1 <= rdy1 | (wake1 & valid);
      rdy2 <= rdy2 | (wake2 & valid);
      if (iss_fire) valid[sel] <= 1'b0;
      if (disp_fire) begin
        valid[free_idx] <= 1'b1;
        rdy1[free_idx]  <= d_rdy1;
        rdy2[free_idx]  <= d_rdy2;
      end
      count_q <= count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    end
  end

  // Payload storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      ps1[free_idx]     <= bus.disp_ps1;
      ps2[free_idx]     <= bus.disp_ps2;
      pd[free_idx]      <= bus.disp_pd;
      payload[free_idx] <= bus.disp_payload;
    end
`ifdef RS_OLDEST_FIRST_EN
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && !(iss_fire && (sel == IDX_W'(i))) && (age[i] != '1))
          age[i] <= age[i] + 1'b1;
      end
      age[free_idx] <= '0;
    end
`endif
  end
endmodule

// File: tb/tb_rs_alu_issue.sv
// tb/tb_rs_alu_issue.sv - directed scoreboard bench for rs_alu_issue
// Define RS_OLDEST_FIRST_EN to match an age-based build of the design.
module tb_rs_alu_issue;
  localparam int DEPTH     = 8;
  localparam int PREG_W    = 7;
  localparam int PAYLOAD_W = 48;

  typedef struct packed {
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [PREG_W-1:0]    pd;
    logic [PAYLOAD_W-1:0] payload;
  } iss_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  iss_t sb[$];
  iss_t exp_e;

  always #5 clk = ~clk;

  rs_alu_issue_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

  rs_alu_issue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every issue strobe must match the oldest outstanding scoreboard entry.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.read_en_alu === 1'b1) begin
      chk("issue_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_e = sb.pop_front();
        chk("iss_ps1", 64'(bus.ps1_in_alu), 64'(exp_e.ps1));
        chk("iss_ps2", 64'(bus.ps2_in_alu), 64'(exp_e.ps2));
        chk("iss_pd", 64'(bus.iss_pd), 64'(exp_e.pd));
        chk("iss_payload", 64'(bus.iss_payload), 64'(exp_e.payload));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                      input logic [PREG_W-1:0] d, input logic [PAYLOAD_W-1:0] pl);
    iss_t e;
    e.ps1 = p1; e.ps2 = p2; e.pd = d; e.payload = pl;
    sb.push_back(e);
  endtask

  task automatic set_disp(input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                          input logic r1, input logic r2,
                          input logic [PREG_W-1:0] d, input logic [PAYLOAD_W-1:0] pl);
    bus.disp_valid   = 1'b1;
    bus.disp_ps1     = p1;
    bus.disp_ps2     = p2;
    bus.disp_ps1_rdy = r1;
    bus.disp_ps2_rdy = r2;
    bus.disp_pd      = d;
    bus.disp_payload = pl;
  endtask

  task automatic disp_cyc(input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                          input logic r1, input logic r2,
                          input logic [PREG_W-1:0] d, input logic [PAYLOAD_W-1:0] pl);
    set_disp(p1, p2, r1, r2, d, pl);
    tick();
    bus.disp_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.disp_valid = 1'b0; bus.disp_ps1 = '0; bus.disp_ps2 = '0;
    bus.disp_ps1_rdy = 1'b0; bus.disp_ps2_rdy = 1'b0; bus.disp_pd = '0; bus.disp_payload = '0;
    bus.wk_alu_en = 1'b0; bus.wk_alu_pd = '0; bus.wk_b_en = 1'b0; bus.wk_b_pd = '0;
    bus.wk_mem_en = 1'b0; bus.wk_mem_pd = '0; bus.flush = 1'b0; bus.iss_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("rst_read_en", 64'(bus.read_en_alu), 64'd0);
    chk("rst_ps1", 64'(bus.ps1_in_alu), 64'd0);
    chk("rst_payload", 64'(bus.iss_payload), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // ready-at-dispatch uop issues the next cycle
    push(7'd5, 7'd0, 7'd20, 48'hA1);
    disp_cyc(7'd5, 7'd0, 1'b1, 1'b1, 7'd20, 48'hA1);
    chk("t1_count1", 64'(bus.count), 64'd1);
    chk("t1_read_en", 64'(bus.read_en_alu), 64'd1);
    chk("t1_ps1", 64'(bus.ps1_in_alu), 64'd5);
    tick();
    chk("t1_count0", 64'(bus.count), 64'd0);

    // mem-port wakeup two cycles later, issue exactly one cycle after it
    disp_cyc(7'd9, 7'd3, 1'b0, 1'b1, 7'd21, 48'hA2);
    chk("t2_wait0", 64'(bus.read_en_alu), 64'd0);
    tick();
    chk("t2_wait1", 64'(bus.read_en_alu), 64'd0);
    chk("t2_count", 64'(bus.count), 64'd1);
    bus.wk_mem_en = 1'b1; bus.wk_mem_pd = 7'd9;
    #1;
    chk("t2_no_bypass", 64'(bus.read_en_alu), 64'd0);
    push(7'd9, 7'd3, 7'd21, 48'hA2);
    tick();
    bus.wk_mem_en = 1'b0;
    #1;
    chk("t2_issue", 64'(bus.read_en_alu), 64'd1);
    tick();
    chk("t2_count0", 64'(bus.count), 64'd0);

    // wakeup in the dispatch cycle is captured
    push(7'd12, 7'd0, 7'd22, 48'hA3);
    bus.wk_alu_en = 1'b1; bus.wk_alu_pd = 7'd12;
    disp_cyc(7'd12, 7'd0, 1'b0, 1'b0, 7'd22, 48'hA3);
    bus.wk_alu_en = 1'b0;
    #1;
    chk("t3_issue", 64'(bus.read_en_alu), 64'd1);
    tick();
    chk("t3_count0", 64'(bus.count), 64'd0);

    // fill, overflow dispatch dropped, one wakeup frees a slot
    for (int i = 0; i < DEPTH; i++)
      disp_cyc(7'(40 + i), 7'd0, 1'b0, 1'b1, 7'(30 + i), 48'(48'hB0 + i));
    chk("t4_full_count", 64'(bus.count), 64'd8);
    chk("t4_full_ready", 64'(bus.disp_ready), 64'd0);
    disp_cyc(7'd60, 7'd0, 1'b1, 1'b1, 7'd31, 48'hBF);
    chk("t4_drop_count", 64'(bus.count), 64'd8);
    chk("t4_drop_noiss", 64'(bus.read_en_alu), 64'd0);
    bus.wk_b_en = 1'b1; bus.wk_b_pd = 7'd43;
    push(7'd43, 7'd0, 7'd33, 48'hB3);
    tick();
    bus.wk_b_en = 1'b0;
    #1;
    chk("t4_issue", 64'(bus.read_en_alu), 64'd1);
    chk("t4_ready_cons", 64'(bus.disp_ready), 64'd0);
    tick();
    chk("t4_count7", 64'(bus.count), 64'd7);
    chk("t4_ready_back", 64'(bus.disp_ready), 64'd1);

    // flush with a held ready entry and a same-cycle dispatch
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("t5_pre_flush", 64'(bus.count), 64'd0);
    bus.iss_ready = 1'b0;
    disp_cyc(7'd70, 7'd0, 1'b0, 1'b1, 7'd60, 48'hC0);
    disp_cyc(7'd71, 7'd0, 1'b0, 1'b1, 7'd61, 48'hC1);
    disp_cyc(7'd72, 7'd0, 1'b1, 1'b1, 7'd62, 48'hC2);
    chk("t5_count3", 64'(bus.count), 64'd3);
    bus.iss_ready = 1'b1;
    bus.flush = 1'b1;
    set_disp(7'd73, 7'd0, 1'b1, 1'b1, 7'd63, 48'hC3);
    #1;
    chk("t5_flush_noiss", 64'(bus.read_en_alu), 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    #1;
    chk("t5_count0", 64'(bus.count), 64'd0);
    repeat (3) tick();
    chk("t5_quiet", 64'(bus.read_en_alu), 64'd0);

    // iss_ready backpressure holds the entry
    bus.iss_ready = 1'b0;
    disp_cyc(7'd80, 7'd81, 1'b1, 1'b1, 7'd40, 48'hD0);
    chk("t6_held", 64'(bus.read_en_alu), 64'd0);
    tick();
    chk("t6_held_count", 64'(bus.count), 64'd1);
    push(7'd80, 7'd81, 7'd40, 48'hD0);
    bus.iss_ready = 1'b1;
    #1;
    chk("t6_release", 64'(bus.read_en_alu), 64'd1);
    tick();
    chk("t6_count0", 64'(bus.count), 64'd0);

    // A lands in idx1, B later in idx0; selection order depends on build
    bus.iss_ready = 1'b0;
    disp_cyc(7'd90, 7'd0, 1'b1, 1'b1, 7'd50, 48'hE0);
    disp_cyc(7'd91, 7'd0, 1'b1, 1'b1, 7'd51, 48'hE1);
    push(7'd90, 7'd0, 7'd50, 48'hE0);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    #1;
    chk("t7_count1", 64'(bus.count), 64'd1);
    disp_cyc(7'd92, 7'd0, 1'b1, 1'b1, 7'd52, 48'hE2);
    chk("t7_count2", 64'(bus.count), 64'd2);
`ifdef RS_OLDEST_FIRST_EN
    push(7'd91, 7'd0, 7'd51, 48'hE1);
    push(7'd92, 7'd0, 7'd52, 48'hE2);
`else
    push(7'd92, 7'd0, 7'd52, 48'hE2);
    push(7'd91, 7'd0, 7'd51, 48'hE1);
`endif
    bus.iss_ready = 1'b1;
    drain();
    tick();
    chk("t7_empty", 64'(bus.count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
